// File: rtl/y_drain_poller.sv
// Polls an upstream register block for available bytes and drains them into a small output FIFO.
// Optional statistics counters are built when Y_DRAIN_POLLER_STATS_EN is defined.
module y_drain_poller #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned POLL_GAP = 0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      enable,
   output logic [2:0]                rd_address,
   output logic                      rd_en,
   input  logic [7:0]                rd_data,
   input  logic                      rd_rdy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_data,
   output logic [$clog2(DEPTH):0]    out_count,
   output logic                      busy,
   output logic [15:0]               drained_cnt,
   output logic [15:0]               empty_polls
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = 8;

   localparam logic [2:0] ADDR_IDLE  = 3'd7;
   localparam logic [2:0] ADDR_STAT  = 3'd2;
   localparam logic [2:0] ADDR_FIFO  = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POLL  = 2'd1,
      ST_FETCH = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t          state_q,  state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic [GW-1:0]   gap_q,    gap_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];

   logic            push_c;
   logic            pop_c;

   assign push_c = (state_q == ST_FETCH) && rd_rdy;
   assign pop_c  = (count_q != '0) && out_ready;

   // Next-state, FIFO pointer and occupancy update
   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;

      case (state_q)
         ST_IDLE: begin
            if (enable && (count_q < CW'(DEPTH))) begin
               state_d = ST_POLL;
            end
         end
         ST_POLL: begin
            if (rd_rdy) begin
               if (rd_data[0]) begin
                  state_d = ST_FETCH;
               end else if (POLL_GAP > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GW'(POLL_GAP);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FETCH: begin
            if (rd_rdy) begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_q <= GW'(1)) begin
               state_d = ST_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gap_d   = '0;
         end
      endcase

      if (push_c) begin
         mem_d[wr_ptr_q] = rd_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         gap_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone qualifies its contents
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   // Upstream strobes decode straight from the state flop so reset drops them at once
   always_comb begin
      rd_address = ADDR_IDLE;
      rd_en      = 1'b0;
      case (state_q)
         ST_POLL:  rd_address = ADDR_STAT;
         ST_FETCH: begin
            rd_address = ADDR_FIFO;
            rd_en      = 1'b1;
         end
         default:  rd_address = ADDR_IDLE;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign out_count = count_q;
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];

`ifdef Y_DRAIN_POLLER_STATS_EN
   logic        empty_poll_c;
   logic [15:0] drained_q, drained_d;
   logic [15:0] empty_q,   empty_d;

   assign empty_poll_c = (state_q == ST_POLL) && rd_rdy && !rd_data[0];

   // Free-running statistics, wrapping naturally at 16 bits
   always_comb begin
      drained_d = drained_q;
      empty_d   = empty_q;
      if (push_c) begin
         drained_d = drained_q + 16'd1;
      end
      if (empty_poll_c) begin
         empty_d = empty_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         drained_q <= '0;
         empty_q   <= '0;
      end else begin
         drained_q <= drained_d;
         empty_q   <= empty_d;
      end
   end

   assign drained_cnt = drained_q;
   assign empty_polls = empty_q;
`else
   assign drained_cnt = '0;
   assign empty_polls = '0;
`endif

endmodule

// File: tb/tb_y_drain_poller.sv
// Directed bench for y_drain_poller: default instance plus a POLL_GAP=3 instance on an empty upstream.
module tb_y_drain_poller;

   logic        CLK;
   logic        RST;

   logic        enable;
   logic [2:0]  rd_address;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        rd_rdy;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_count;
   logic        busy;
   logic [15:0] drained_cnt;
   logic [15:0] empty_polls;

   logic        enable_g;
   logic [2:0]  rd_address_g;
   logic        rd_en_g;
   logic [7:0]  rd_data_g;
   logic        rd_rdy_g;
   logic        out_valid_g;
   logic        out_ready_g;
   logic [7:0]  out_data_g;
   logic [2:0]  out_count_g;
   logic        busy_g;
   logic [15:0] drained_cnt_g;
   logic [15:0] empty_polls_g;

   int passed = 0;
   int total  = 0;

   // Upstream register block: status at address 2, FIFO head at address 3
   logic [7:0] up_mem [16];
   logic [3:0] up_rd = '0;
   logic [3:0] up_wr;

   always_comb begin
      rd_data = 8'h00;
      if (rd_address == 3'd2) rd_data = {7'd0, (up_rd != up_wr)};
      else if (rd_address == 3'd3) rd_data = up_mem[up_rd];
   end

   always @(posedge CLK) begin
      if (rd_en && rd_rdy && (rd_address == 3'd3)) up_rd <= up_rd + 4'd1;
   end

   y_drain_poller #(.DEPTH(4), .POLL_GAP(0)) dut (
      .CLK(CLK), .RST(RST), .enable(enable),
      .rd_address(rd_address), .rd_en(rd_en), .rd_data(rd_data), .rd_rdy(rd_rdy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .busy(busy),
      .drained_cnt(drained_cnt), .empty_polls(empty_polls)
   );

   y_drain_poller #(.DEPTH(4), .POLL_GAP(3)) dut_g (
      .CLK(CLK), .RST(RST), .enable(enable_g),
      .rd_address(rd_address_g), .rd_en(rd_en_g), .rd_data(rd_data_g), .rd_rdy(rd_rdy_g),
      .out_valid(out_valid_g), .out_ready(out_ready_g), .out_data(out_data_g),
      .out_count(out_count_g), .busy(busy_g),
      .drained_cnt(drained_cnt_g), .empty_polls(empty_polls_g)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic load_byte(input logic [7:0] b);
      up_mem[up_wr] = b;
      up_wr = up_wr + 4'd1;
   endtask

   initial begin
      logic [7:0] exp_b [6];
      int k;
      logic [15:0] exp_drained;
      logic [15:0] exp_empty;
      logic [15:0] exp_empty_g;

      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      RST = 1'b1;
      enable = 1'b0;  rd_rdy = 1'b1;  out_ready = 1'b0;
      enable_g = 1'b0; rd_rdy_g = 1'b1; out_ready_g = 1'b1; rd_data_g = 8'h00;
      up_wr = '0;
      for (int i = 0; i < 16; i++) up_mem[i] = 8'h00;

      repeat (2) @(negedge CLK);
      check("rst_addr",   16'(rd_address), 16'd7);
      check("rst_rden",   16'(rd_en), 16'd0);
      check("rst_valid",  16'(out_valid), 16'd0);
      check("rst_count",  16'(out_count), 16'd0);
      check("rst_busy",   16'(busy), 16'd0);
      check("rst_drained", drained_cnt, 16'd0);
      RST = 1'b0;

      // Two bytes drained three cycles apart, then empty polls
      load_byte(8'h5A); load_byte(8'hC3);
      out_ready = 1'b1; enable = 1'b1;
      tick(); check("a_poll_addr", 16'(rd_address), 16'd2);
              check("a_poll_busy", 16'(busy), 16'd1);
      tick(); check("a_fetch_en",  16'(rd_en), 16'd1);
              check("a_fetch_addr", 16'(rd_address), 16'd3);
      tick(); check("a_out0_valid", 16'(out_valid), 16'd1);
              check("a_out0_data", 16'(out_data), 16'h5A);
              check("a_out0_cnt",  16'(out_count), 16'd1);
      tick(); check("a_pop0_cnt",  16'(out_count), 16'd0);
              check("a_poll2_addr", 16'(rd_address), 16'd2);
      tick(); check("a_fetch2_en", 16'(rd_en), 16'd1);
      tick(); check("a_out1_data", 16'(out_data), 16'hC3);
              check("a_out1_valid", 16'(out_valid), 16'd1);
      tick(); check("a_poll3_addr", 16'(rd_address), 16'd2);
      tick(); check("a_empty_idle", 16'(busy), 16'd0);
      tick(); check("a_repoll",    16'(rd_address), 16'd2);
      enable = 1'b0;
      tick(); check("a_stop_busy", 16'(busy), 16'd0);
`ifdef Y_DRAIN_POLLER_STATS_EN
      exp_drained = 16'd2; exp_empty = 16'd2;
`else
      exp_drained = 16'd0; exp_empty = 16'd0;
`endif
      check("a_drained_cnt", drained_cnt, exp_drained);
      check("a_empty_polls", empty_polls, exp_empty);

      // Six bytes upstream, consumer stalled: buffer fills to four and the FSM parks
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) load_byte(exp_b[i]);
      enable = 1'b1;
      repeat (20) tick();
      check("b_full_cnt",  16'(out_count), 16'd4);
      check("b_full_busy", 16'(busy), 16'd0);
      check("b_full_addr", 16'(rd_address), 16'd7);
      check("b_head",      16'(out_data), 16'h11);
      out_ready = 1'b1;
      k = 0;
      for (int t = 0; t < 60 && k < 6; t++) begin
         if (out_valid) begin
            check("b_drain_data", 16'(out_data), 16'(exp_b[k]));
            k++;
         end
         tick();
      end
      check("b_drain_total", 16'(k), 16'd6);
      enable = 1'b0;
      repeat (3) tick();
      check("b_end_cnt",  16'(out_count), 16'd0);
      check("b_end_busy", 16'(busy), 16'd0);

      // rd_rdy stall during FETCH; the byte present when rd_rdy rises is captured once
      load_byte(8'h77);
      enable = 1'b1;
      tick();
      tick(); check("c_fetch_en", 16'(rd_en), 16'd1);
      rd_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) up_mem[up_rd] = 8'h78;
         tick();
         check("c_stall_en",   16'(rd_en), 16'd1);
         check("c_stall_addr", 16'(rd_address), 16'd3);
         check("c_stall_cnt",  16'(out_count), 16'd0);
      end
      rd_rdy = 1'b1; enable = 1'b0;
      tick(); check("c_push_cnt",  16'(out_count), 16'd1);
              check("c_push_data", 16'(out_data), 16'h78);
              check("c_done_busy", 16'(busy), 16'd0);
      tick(); check("c_popped_cnt", 16'(out_count), 16'd0);
              check("c_popped_valid", 16'(out_valid), 16'd0);

      // Simultaneous push and pop with one entry buffered
      out_ready = 1'b0;
      load_byte(8'hA1); load_byte(8'hB2);
      enable = 1'b1;
      repeat (3) tick();
      check("d_one_cnt",  16'(out_count), 16'd1);
      check("d_one_data", 16'(out_data), 16'hA1);
      repeat (2) tick();
      check("d_fetch_en", 16'(rd_en), 16'd1);
      out_ready = 1'b1; enable = 1'b0;
      tick(); check("d_pp_cnt",  16'(out_count), 16'd1);
              check("d_pp_data", 16'(out_data), 16'hB2);
      tick(); check("d_end_cnt", 16'(out_count), 16'd0);

      // Reset in the middle of FETCH with two bytes buffered
      out_ready = 1'b0;
      load_byte(8'hD1); load_byte(8'hD2); load_byte(8'hD3);
      enable = 1'b1;
      repeat (6) tick();
      check("e_two_cnt", 16'(out_count), 16'd2);
      repeat (2) tick();
      check("e_fetch_en", 16'(rd_en), 16'd1);
      #2 RST = 1'b1;
      #1;
      check("e_rst_rden",  16'(rd_en), 16'd0);
      check("e_rst_addr",  16'(rd_address), 16'd7);
      check("e_rst_valid", 16'(out_valid), 16'd0);
      check("e_rst_cnt",   16'(out_count), 16'd0);
      enable = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      tick();
      check("e_post_cnt",     16'(out_count), 16'd0);
      check("e_post_busy",    16'(busy), 16'd0);
      check("e_post_drained", drained_cnt, 16'd0);
      check("e_post_empty",   empty_polls, 16'd0);

      // POLL_GAP=3 on an empty upstream: POLL, three GAP cycles, IDLE, repeat
      enable_g = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("g_addr", 16'(rd_address_g), (i % 5 == 1) ? 16'd2 : 16'd7);
         check("g_busy", 16'(busy_g), (i % 5 == 0) ? 16'd0 : 16'd1);
      end
      check("g_rden", 16'(rd_en_g), 16'd0);
`ifdef Y_DRAIN_POLLER_STATS_EN
      exp_empty_g = 16'd3;
`else
      exp_empty_g = 16'd0;
`endif
      check("g_empty_polls", empty_polls_g, exp_empty_g);
      check("g_out_cnt", 16'(out_count_g), 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
